dcache_read_sequencer: RTL and testbench

//  Memory-read stage sequencer: accepts one instruction's set of up to NOPS operand addresses,

---
 rtl/dcache_read_sequencer.sv | 160 ++++++++++++++++
 tb/tb_dcache_read_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_read_sequencer.sv
// ---------------------------------------------------------------------------
// dcache_read_sequencer
//
// Memory-read stage sequencer between address generation and execute.
// It accepts one instruction's set of up to NOPS operand addresses and issues
// one dcache read per valid operand, lowest index first, with a single
// request outstanding at a time. Each returned line is captured in that
// operand's data slot. The complete set is then presented to execute in one
// valid/ready handshake. A new set may be accepted in the same cycle the
// previous one is consumed.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low; clears all state
//   a_valid/a_ready  upstream operand-set handshake
//   op_address       operand k address at [k*ADDR_W +: ADDR_W]
//   op_valid         operand k is read when bit k is set
//   e_valid/e_ready  downstream (execute) handshake
//   data_out         operand k data at [k*DATA_W +: DATA_W]
//   data_valid       operand mask of the presented set
//   rd_req_*         dcache read request channel (valid/ready/address)
//   rd_dp_*          dcache read data channel (valid/ready/read_data)
// ---------------------------------------------------------------------------
module dcache_read_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int NOPS   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [NOPS*ADDR_W-1:0] op_address,
  input  logic [NOPS-1:0]        op_valid,
  output logic                   e_valid,
  input  logic                   e_ready,
  output logic [NOPS*DATA_W-1:0] data_out,
  output logic [NOPS-1:0]        data_valid,
  output logic                   rd_req_valid,
  input  logic                   rd_req_ready,
  output logic [ADDR_W-1:0]      rd_req_address,
  input  logic                   rd_dp_valid,
  output logic                   rd_dp_ready,
  input  logic [DATA_W-1:0]      rd_dp_read_data
);

  localparam int IDX_W = (NOPS > 1) ? $clog2(NOPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q [NOPS];
  logic [DATA_W-1:0] data_q [NOPS];
  logic [NOPS-1:0]   pending_q, pending_d;
  logic [NOPS-1:0]   pending_after;
  logic [NOPS-1:0]   data_valid_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              accept;
  logic              capture;

  // Index of the lowest set bit; the descending scan lets bit 0 win.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NOPS-1:0] mask);
    lowest_set = '0;
    for (int k = NOPS - 1; k >= 0; k--) begin
      if (mask[k]) lowest_set = IDX_W'(k);
    end
  endfunction

  // Handshake outputs are pure decodes of the state register. In reset the
  // state is IDLE, so a_ready=1 and the others are 0.
  assign a_ready      = (state_q == IDLE) || ((state_q == DONE) && e_ready);
  assign rd_req_valid = (state_q == REQ);
  assign rd_dp_ready  = (state_q == RESP);
  assign e_valid      = (state_q == DONE);

  assign accept  = a_valid && a_ready;
  // A response arriving outside RESP is ignored.
  assign capture = (state_q == RESP) && rd_dp_valid;

  assign pending_after  = pending_q & ~(NOPS'(1) << idx_q);
  assign rd_req_address = addr_q[idx_q];
  assign data_valid     = data_valid_q;

  for (genvar k = 0; k < NOPS; k++) begin : g_pack
    assign data_out[k*DATA_W +: DATA_W] = data_q[k];
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          pending_d = op_valid;
          if (op_valid == '0) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            idx_d   = lowest_set(op_valid);
          end
        end else if ((state_q == DONE) && e_ready) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (rd_req_ready) state_d = RESP;
      end
      RESP: begin
        if (rd_dp_valid) begin
          pending_d = pending_after;
          if (pending_after != '0) begin
            state_d = REQ;
            idx_d   = lowest_set(pending_after);
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values of the previous cycle regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= '0;
      data_valid_q <= '0;
      // NOTE: the address and data banks are small register arrays, not RAM,
      // so they are cleared too; data_out reads 0 after reset and
      // rd_req_address is never X.
      for (int k = 0; k < NOPS; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      if (accept) begin
        data_valid_q <= op_valid;
        for (int k = 0; k < NOPS; k++) begin
          addr_q[k] <= op_address[k*ADDR_W +: ADDR_W];
        end
      end
      if (capture) data_q[idx_q] <= rd_dp_read_data;
    end
  end

endmodule

// File: tb/tb_dcache_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dcache_read_sequencer
//
// Directed bench for dcache_read_sequencer (NOPS=2). Each launched operand
// set pushes its expected request addresses, the dcache data to return, and
// the expected presented set (mask plus full data_out, including stale slots
// kept by a small data model) into queues. A lock-step loop plays the dcache
// with configurable stalls, pops and compares request addresses and
// presented sets, and measures accept-to-e_valid latency.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dcache_read_sequencer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int NOPS   = 2;

  logic                   clk;
  logic                   reset;
  logic                   a_valid;
  logic                   a_ready;
  logic [NOPS*ADDR_W-1:0] op_address;
  logic [NOPS-1:0]        op_valid;
  logic                   e_valid;
  logic                   e_ready;
  logic [NOPS*DATA_W-1:0] data_out;
  logic [NOPS-1:0]        data_valid;
  logic                   rd_req_valid;
  logic                   rd_req_ready;
  logic [ADDR_W-1:0]      rd_req_address;
  logic                   rd_dp_valid;
  logic                   rd_dp_ready;
  logic [DATA_W-1:0]      rd_dp_read_data;

  dcache_read_sequencer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NOPS  (NOPS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .op_address     (op_address),
    .op_valid       (op_valid),
    .e_valid        (e_valid),
    .e_ready        (e_ready),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_address (rd_req_address),
    .rd_dp_valid    (rd_dp_valid),
    .rd_dp_ready    (rd_dp_ready),
    .rd_dp_read_data(rd_dp_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NOPS-1:0]        mask;
    logic [NOPS*DATA_W-1:0] data;
  } set_t;

  set_t                   exp_set_q [$];
  logic [ADDR_W-1:0]      exp_req_q [$];
  logic [DATA_W-1:0]      exp_rsp_q [$];
  logic [NOPS*DATA_W-1:0] model_data;

  int tests = 0;
  int fails = 0;
  int req_stall = 0;
  int dp_delay  = 0;
  bit spurious  = 1'b0;

  localparam logic [DATA_W-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a new operand set; the caller is at a falling edge.
  task automatic launch(input logic [NOPS-1:0] mask,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    logic [ADDR_W-1:0] a [NOPS];
    logic [DATA_W-1:0] d [NOPS];
    set_t s;
    a[0] = a0; a[1] = a1;
    d[0] = d0; d[1] = d1;
    a_valid    = 1'b1;
    op_address = {a1, a0};
    op_valid   = mask;
    for (int k = 0; k < NOPS; k++) begin
      if (mask[k]) begin
        exp_req_q.push_back(a[k]);
        exp_rsp_q.push_back(d[k]);
        model_data[k*DATA_W +: DATA_W] = d[k];
      end
    end
    s.mask = mask;
    s.data = model_data;
    exp_set_q.push_back(s);
    #1;
    check("a_ready at launch", a_ready, 1'b1);
  endtask

  // Play the dcache until e_valid, check the set, hold it for 'hold' cycles,
  // then leave e_ready=1 at a falling edge.
  task automatic serve(input int exp_lat, input int hold);
    int   cyc;
    int   req_wait;
    int   dp_wait;
    bit   done;
    set_t s;
    logic [NOPS*DATA_W-1:0] snap;
    cyc = 0; req_wait = 0; dp_wait = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      a_valid = 1'b0; e_ready = 1'b0;
      rd_req_ready = 1'b0; rd_dp_valid = 1'b0; rd_dp_read_data = JUNK;
      if (e_valid) begin
        done = 1'b1;
      end else begin
        if (rd_req_valid) begin
          if (exp_req_q.size() == 0) begin
            tests++; fails++;
            $error("FAIL unexpected request: observed %0h expected none", rd_req_address);
          end else begin
            check("request address", rd_req_address, exp_req_q[0]);
          end
          if (spurious) begin
            rd_dp_valid = 1'b1;
            check("rd_dp_ready in REQ", rd_dp_ready, 1'b0);
          end
          if (req_wait >= req_stall) begin
            rd_req_ready = 1'b1;
            req_wait = 0;
            if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
          end else begin
            req_wait++;
          end
        end
        if (rd_dp_ready) begin
          if (dp_wait >= dp_delay) begin
            rd_dp_valid = 1'b1;
            rd_dp_read_data = (exp_rsp_q.size() != 0) ? exp_rsp_q.pop_front() : JUNK;
            dp_wait = 0;
          end else begin
            dp_wait++;
          end
        end
      end
    end
    check("e_valid before timeout", e_valid, 1'b1);
    check("latency", cyc, exp_lat);
    check("requests outstanding", exp_req_q.size(), 0);
    if (exp_set_q.size() == 0) begin
      tests++; fails++;
      $error("FAIL set scoreboard: observed set with mask %0h expected none", data_valid);
    end else begin
      s = exp_set_q.pop_front();
      check("data_valid", data_valid, s.mask);
      check("data_out", data_out, s.data);
    end
    snap = data_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold e_valid", e_valid, 1'b1);
      check("hold data_out", data_out, snap);
      check("hold rd_req_valid", rd_req_valid, 1'b0);
    end
    e_ready = 1'b1;
  endtask

  task automatic finish_idle();
    @(negedge clk);
    e_ready = 1'b0;
    check("idle e_valid", e_valid, 1'b0);
    check("idle a_ready", a_ready, 1'b1);
    check("idle rd_req_valid", rd_req_valid, 1'b0);
  endtask

  task automatic idle_spurious(input int n);
    logic [NOPS-1:0] dv;
    dv = data_valid;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_dp_valid = 1'b1;
      rd_dp_read_data = JUNK;
      #1;
      check("idle rd_dp_ready", rd_dp_ready, 1'b0);
      check("idle a_ready spurious", a_ready, 1'b1);
    end
    @(negedge clk);
    rd_dp_valid = 1'b0;
    check("spurious data_out", data_out, model_data);
    check("spurious data_valid", data_valid, dv);
    check("spurious e_valid", e_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0; a_valid = 1'b0; op_address = '0; op_valid = '0; e_ready = 1'b0;
    rd_req_ready = 1'b0; rd_dp_valid = 1'b0; rd_dp_read_data = '0;
    model_data = '0;
    repeat (2) @(negedge clk);
    check("reset a_ready", a_ready, 1'b1);
    check("reset e_valid", e_valid, 1'b0);
    check("reset rd_req_valid", rd_req_valid, 1'b0);
    check("reset rd_dp_ready", rd_dp_ready, 1'b0);
    check("reset data_valid", data_valid, 2'b00);
    check("reset data_out", data_out, '0);
    reset = 1'b1;

    // Single operand, minimum latency.
    @(negedge clk);
    launch(2'b01, 32'h1000, 32'h0, 64'hDEAD_BEEF_0000_0001, 64'h0);
    serve(3, 0);
    finish_idle();

    // Two operands in ascending order.
    launch(2'b11, 32'h2000, 32'h3000, 64'h2222_0000_2222_0000, 64'h3333_0000_3333_0000);
    serve(5, 0);
    finish_idle();

    // Operand 1 only with request and response stalls; slot 0 stays stale.
    req_stall = 3; dp_delay = 4;
    launch(2'b10, 32'h5555, 32'h4000, 64'h0, 64'h4444_4444_4444_4444);
    serve(10, 0);
    req_stall = 0; dp_delay = 0;
    finish_idle();

    // Spurious responses in IDLE and during REQ.
    idle_spurious(3);
    spurious = 1'b1;
    launch(2'b11, 32'h5000, 32'h5008, 64'h5050_5050_0000_0000, 64'h0000_0000_5858_5858);
    serve(5, 0);
    spurious = 1'b0;
    finish_idle();

    // Empty set, held two cycles, then consumed together with a new set.
    launch(2'b00, 32'hEEEE, 32'hFFFF, 64'h0, 64'h0);
    serve(1, 2);
    launch(2'b11, 32'h6000, 32'h7000, 64'h6666_6666_0000_0006, 64'h7777_7777_0000_0007);
    serve(5, 0);
    finish_idle();

    // Asynchronous reset while a request is stalled.
    req_stall = 5;
    launch(2'b11, 32'h8000, 32'h9000, 64'h8, 64'h9);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("pre-reset rd_req_valid", rd_req_valid, 1'b1);
    check("pre-reset address", rd_req_address, 32'h8000);
    #2 reset = 1'b0;
    #1;
    check("mid reset rd_req_valid", rd_req_valid, 1'b0);
    check("mid reset e_valid", e_valid, 1'b0);
    check("mid reset data_valid", data_valid, 2'b00);
    check("mid reset a_ready", a_ready, 1'b1);
    check("mid reset data_out", data_out, '0);
    exp_req_q.delete(); exp_rsp_q.delete(); exp_set_q.delete();
    model_data = '0;
    req_stall = 0;
    @(negedge clk);
    reset = 1'b1;

    // Recovery after reset.
    @(negedge clk);
    launch(2'b01, 32'hA000, 32'hB000, 64'hA0A0_A0A0_A0A0_A0A0, 64'h0);
    serve(3, 0);
    finish_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
